// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, flush, store lane alignment and misalignment detection.
// Optional build macro EX_MEM_STALL_CNT_EN adds a saturating stall_cnt output.
module ex_mem_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int PC_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic                  ex_reg_wr,
  input  logic                  ex_mem_wr,
  input  logic                  ex_mem_rd,
  input  logic [1:0]            ex_mem_size,
  input  logic                  ex_mem_sext,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic [REG_ADDR_W-1:0] ex_waddr,
  input  logic [PC_W-1:0]       ex_pc,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_reg_wr,
  output logic                  mem_mem_wr,
  output logic                  mem_mem_rd,
  output logic                  mem_mem_sext,
  output logic [1:0]            mem_mem_size,
  output logic [DATA_W-1:0]     mem_alu_result,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [REG_ADDR_W-1:0] mem_waddr,
  output logic [PC_W-1:0]       mem_pc,
  output logic                  mem_misalign
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int NB  = DATA_W / 8;
  localparam int OFS = $clog2(NB);

  localparam logic [NB-1:0] BYTE_MASK = NB'(1);
  localparam logic [NB-1:0] HALF_MASK = NB'(3);
  localparam logic [NB-1:0] WORD_MASK = NB'(15);
  localparam logic [NB-1:0] ALL_MASK  = '1;

  logic [OFS-1:0]    lane;
  logic [NB-1:0]     be_aligned;
  logic [DATA_W-1:0] wdata_aligned;
  logic              size_misalign;
  logic              is_mem_op;
  logic              is_load;
  logic              bad_access;
  logic              live;

  assign lane     = ex_alu_result[OFS-1:0];
  assign ex_ready = !mem_valid || mem_ready;

  // Replicate the right-aligned store operand across every lane so the
  // byte enables alone select where it lands in memory.
  always_comb begin
    be_aligned    = '0;
    wdata_aligned = ex_store_data;
    size_misalign = 1'b0;
    case (ex_mem_size)
      2'd0: begin
        be_aligned    = BYTE_MASK << lane;
        wdata_aligned = {NB{ex_store_data[7:0]}};
      end
      2'd1: begin
        be_aligned    = HALF_MASK << lane;
        wdata_aligned = {(NB/2){ex_store_data[15:0]}};
        size_misalign = lane[0];
      end
      2'd2: begin
        be_aligned    = WORD_MASK << lane;
        wdata_aligned = {(NB/4){ex_store_data[31:0]}};
        size_misalign = (lane[1:0] != 2'b00);
      end
      default: begin
        be_aligned    = ALL_MASK;
        wdata_aligned = ex_store_data;
        size_misalign = (DATA_W == 32) ? 1'b1 : (lane != '0);
      end
    endcase
  end

  // A simultaneous read and write request is resolved as a store.
  assign is_mem_op  = ex_valid && (ex_mem_wr || ex_mem_rd);
  assign is_load    = ex_mem_rd && !ex_mem_wr;
  assign bad_access = is_mem_op && size_misalign;
  assign live       = ex_valid && !bad_access;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mem_valid      <= 1'b0;
      mem_reg_wr     <= 1'b0;
      mem_mem_wr     <= 1'b0;
      mem_mem_rd     <= 1'b0;
      mem_mem_sext   <= 1'b0;
      mem_mem_size   <= 2'd0;
      mem_alu_result <= '0;
      mem_wdata      <= '0;
      mem_be         <= '0;
      mem_waddr      <= '0;
      mem_pc         <= '0;
      mem_misalign   <= 1'b0;
    end else if (ex_ready) begin
      mem_valid      <= ex_valid;
      mem_reg_wr     <= live && ex_reg_wr;
      mem_mem_wr     <= live && ex_mem_wr;
      mem_mem_rd     <= live && is_load;
      mem_mem_sext   <= ex_mem_sext;
      mem_mem_size   <= ex_mem_size;
      mem_alu_result <= ex_alu_result;
      mem_wdata      <= wdata_aligned;
      mem_be         <= (live && is_mem_op) ? be_aligned : '0;
      mem_waddr      <= ex_waddr;
      mem_pc         <= ex_pc;
      mem_misalign   <= bad_access;
    end
  end

`ifdef EX_MEM_STALL_CNT_EN
  // Flush deliberately leaves the counter running so stall statistics survive squashes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (mem_valid && !mem_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage (DATA_W=32); checks stall_cnt when EX_MEM_STALL_CNT_EN is defined.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_reg_wr;
  logic        ex_mem_wr;
  logic        ex_mem_rd;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_sext;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_pc;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_reg_wr;
  logic        mem_mem_wr;
  logic        mem_mem_rd;
  logic        mem_mem_sext;
  logic [1:0]  mem_mem_size;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_pc;
  logic        mem_misalign;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int passed = 0;
  int total  = 0;

  ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(5), .PC_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_reg_wr      (ex_reg_wr),
    .ex_mem_wr      (ex_mem_wr),
    .ex_mem_rd      (ex_mem_rd),
    .ex_mem_size    (ex_mem_size),
    .ex_mem_sext    (ex_mem_sext),
    .ex_alu_result  (ex_alu_result),
    .ex_store_data  (ex_store_data),
    .ex_waddr       (ex_waddr),
    .ex_pc          (ex_pc),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_reg_wr     (mem_reg_wr),
    .mem_mem_wr     (mem_mem_wr),
    .mem_mem_rd     (mem_mem_rd),
    .mem_mem_sext   (mem_mem_sext),
    .mem_mem_size   (mem_mem_size),
    .mem_alu_result (mem_alu_result),
    .mem_wdata      (mem_wdata),
    .mem_be         (mem_be),
    .mem_waddr      (mem_waddr),
    .mem_pc         (mem_pc),
    .mem_misalign   (mem_misalign)
`ifdef EX_MEM_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic rw, input logic mw, input logic mr,
                        input logic [1:0] sz, input logic sx, input logic [31:0] alu,
                        input logic [31:0] sd, input logic [4:0] wa, input logic [31:0] pc);
    ex_valid      = v;
    ex_reg_wr     = rw;
    ex_mem_wr     = mw;
    ex_mem_rd     = mr;
    ex_mem_size   = sz;
    ex_mem_sext   = sx;
    ex_alu_result = alu;
    ex_store_data = sd;
    ex_waddr      = wa;
    ex_pc         = pc;
  endtask

  task automatic set_idle;
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    flush     = $urandom_range(0, 1);
    mem_ready = $urandom_range(0, 1);
    set_ex($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           2'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom, $urandom, 5'($urandom), $urandom);
    tick;
    tick;
    total++;
    if ({mem_valid, mem_reg_wr, mem_mem_wr, mem_mem_rd, mem_mem_sext, mem_misalign} !== 6'b0) begin
      $display("FAIL reset_ctrl: got %b expected 000000",
               {mem_valid, mem_reg_wr, mem_mem_wr, mem_mem_rd, mem_mem_sext, mem_misalign});
    end else passed++;
    total++;
    if ({mem_be, mem_wdata, mem_alu_result, mem_pc, mem_waddr, mem_mem_size} !== '0) begin
      $display("FAIL reset_data: be=%h wdata=%h alu=%h pc=%h waddr=%h size=%h expected all 0",
               mem_be, mem_wdata, mem_alu_result, mem_pc, mem_waddr, mem_mem_size);
    end else passed++;
    total++;
    if (ex_ready !== 1'b1) $display("FAIL reset_ex_ready: got %b expected 1", ex_ready);
    else passed++;
`ifdef EX_MEM_STALL_CNT_EN
    total++;
    if (stall_cnt !== 32'd0) $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    else passed++;
`endif
    rst       = 1'b0;
    flush     = 1'b0;
    mem_ready = 1'b1;
    set_idle;
  endtask

  task automatic test_store_byte;
    mem_ready = 1'b1;
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 5'd0, 32'h100);
    tick;
    total++;
    if (mem_be !== 4'b1000) $display("FAIL store_byte_be: got %b expected 1000", mem_be);
    else passed++;
    total++;
    if (mem_wdata !== 32'hABAB_ABAB) $display("FAIL store_byte_wdata: got %h expected ababab ab", mem_wdata);
    else passed++;
    total++;
    if ({mem_valid, mem_mem_wr, mem_mem_rd} !== 3'b110)
      $display("FAIL store_byte_ctrl: valid/wr/rd got %b expected 110", {mem_valid, mem_mem_wr, mem_mem_rd});
    else passed++;
    set_idle;
  endtask

  task automatic test_hold;
    mem_ready = 1'b1;
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_1234, 5'd3, 32'h200);
    tick;
    mem_ready = 1'b0;
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 32'h0000_3000, 32'h0000_FFFF, 5'd7, 32'h300);
    #1;
    total++;
    if (ex_ready !== 1'b0) $display("FAIL hold_ex_ready: got %b expected 0", ex_ready);
    else passed++;
`ifdef EX_MEM_STALL_CNT_EN
    total++;
    if (stall_cnt !== 32'd0) $display("FAIL hold_stall_start: got %0d expected 0", stall_cnt);
    else passed++;
`endif
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if ({mem_valid, mem_mem_wr, mem_mem_rd, mem_be, mem_wdata, mem_pc, mem_waddr} !==
          {1'b1, 1'b1, 1'b0, 4'b1100, 32'h1234_1234, 32'h200, 5'd3})
        $display("FAIL hold_stable cycle %0d: valid=%b wr=%b rd=%b be=%b wdata=%h pc=%h waddr=%0d expected 1 1 0 1100 12341234 200 3",
                 i, mem_valid, mem_mem_wr, mem_mem_rd, mem_be, mem_wdata, mem_pc, mem_waddr);
      else passed++;
    end
`ifdef EX_MEM_STALL_CNT_EN
    total++;
    if (stall_cnt !== 32'd3) $display("FAIL hold_stall_cnt: got %0d expected 3", stall_cnt);
    else passed++;
`endif
    mem_ready = 1'b1;
    set_idle;
    tick;
    total++;
    if (mem_valid !== 1'b0) $display("FAIL hold_drain: mem_valid got %b expected 0", mem_valid);
    else passed++;
  endtask

  task automatic test_misalign;
    mem_ready = 1'b1;
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_2002, 32'h0, 5'd9, 32'h0040_0100);
    tick;
    total++;
    if ({mem_valid, mem_misalign, mem_mem_rd, mem_mem_wr, mem_reg_wr, mem_be} !== {5'b11000, 4'b0000})
      $display("FAIL misalign_ctrl: valid=%b mis=%b rd=%b wr=%b reg_wr=%b be=%b expected 1 1 0 0 0 0000",
               mem_valid, mem_misalign, mem_mem_rd, mem_mem_wr, mem_reg_wr, mem_be);
    else passed++;
    total++;
    if (mem_pc !== 32'h0040_0100) $display("FAIL misalign_pc: got %h expected 00400100", mem_pc);
    else passed++;
    total++;
    if (mem_alu_result !== 32'h0000_2002) $display("FAIL misalign_addr: got %h expected 00002002", mem_alu_result);
    else passed++;
    set_idle;
  endtask

  task automatic test_flush;
    mem_ready = 1'b1;
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 5'd4, 32'h500);
    tick;
    mem_ready = 1'b0;
    flush     = 1'b1;
    set_ex(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_4004, 32'h1, 5'd5, 32'h600);
    tick;
    total++;
    if ({mem_valid, mem_reg_wr, mem_mem_wr, mem_mem_rd, mem_misalign, mem_be} !== 9'b0)
      $display("FAIL flush_ctrl: valid=%b reg_wr=%b wr=%b rd=%b mis=%b be=%b expected all 0",
               mem_valid, mem_reg_wr, mem_mem_wr, mem_mem_rd, mem_misalign, mem_be);
    else passed++;
    total++;
    if (mem_pc !== 32'h0) $display("FAIL flush_pc: got %h expected 0", mem_pc);
    else passed++;
`ifdef EX_MEM_STALL_CNT_EN
    total++;
    if (stall_cnt !== 32'd4) $display("FAIL flush_keeps_stall_cnt: got %0d expected 4", stall_cnt);
    else passed++;
`endif
    flush = 1'b0;
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 5'd0, 32'h700);
    #1;
    total++;
    if (ex_ready !== 1'b1) $display("FAIL flush_ex_ready: got %b expected 1", ex_ready);
    else passed++;
    tick;
    total++;
    if ({mem_valid, mem_mem_wr, mem_be, mem_wdata, mem_pc} !== {2'b11, 4'b1111, 32'hCAFE_F00D, 32'h700})
      $display("FAIL flush_next_accept: valid=%b wr=%b be=%b wdata=%h pc=%h expected 1 1 1111 cafef00d 700",
               mem_valid, mem_mem_wr, mem_be, mem_wdata, mem_pc);
    else passed++;
    mem_ready = 1'b1;
    set_idle;
    tick;
  endtask

  task automatic test_bubble;
    mem_ready = 1'b1;
    set_ex(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_1234, 32'h55, 5'd4, 32'h800);
    tick;
    total++;
    if ({mem_valid, mem_reg_wr, mem_mem_wr, mem_mem_rd, mem_misalign, mem_be} !== 9'b0)
      $display("FAIL bubble_ctrl: valid=%b reg_wr=%b wr=%b rd=%b mis=%b be=%b expected all 0",
               mem_valid, mem_reg_wr, mem_mem_wr, mem_mem_rd, mem_misalign, mem_be);
    else passed++;
    total++;
    if (mem_alu_result !== 32'h0000_1234) $display("FAIL bubble_data: alu got %h expected 00001234", mem_alu_result);
    else passed++;
    set_idle;
  endtask

  typedef struct packed {
    logic [1:0]  size;
    logic [31:0] addr;
    logic        wr;
    logic        rd;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        mis;
    logic        exp_wr;
    logic        exp_rd;
  } lane_vec_t;

  task automatic test_lanes;
    lane_vec_t v [8];
    v[0] = '{2'd0, 32'h01, 1'b1, 1'b0, 4'b0010, 32'hBBBB_BBBB, 1'b0, 1'b1, 1'b0};
    v[1] = '{2'd1, 32'h02, 1'b1, 1'b0, 4'b1100, 32'hAABB_AABB, 1'b0, 1'b1, 1'b0};
    v[2] = '{2'd1, 32'h01, 1'b1, 1'b0, 4'b0000, 32'hAABB_AABB, 1'b1, 1'b0, 1'b0};
    v[3] = '{2'd2, 32'h00, 1'b1, 1'b0, 4'b1111, 32'h8899_AABB, 1'b0, 1'b1, 1'b0};
    v[4] = '{2'd3, 32'h00, 1'b1, 1'b0, 4'b0000, 32'h8899_AABB, 1'b1, 1'b0, 1'b0};
    v[5] = '{2'd0, 32'h03, 1'b0, 1'b1, 4'b1000, 32'hBBBB_BBBB, 1'b0, 1'b0, 1'b1};
    v[6] = '{2'd0, 32'h00, 1'b1, 1'b1, 4'b0001, 32'hBBBB_BBBB, 1'b0, 1'b1, 1'b0};
    v[7] = '{2'd2, 32'h01, 1'b0, 1'b1, 4'b0000, 32'h8899_AABB, 1'b1, 1'b0, 1'b0};
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_ex(1'b1, 1'b1, v[i].wr, v[i].rd, v[i].size, 1'b1, v[i].addr, 32'h8899_AABB, 5'd12, 32'h1000 + i);
      tick;
      total++;
      if ({mem_be, mem_wdata, mem_misalign, mem_mem_wr, mem_mem_rd, mem_reg_wr, mem_mem_sext} !==
          {v[i].be, v[i].wdata, v[i].mis, v[i].exp_wr, v[i].exp_rd, !v[i].mis, 1'b1})
        $display("FAIL lanes[%0d]: be=%b wdata=%h mis=%b wr=%b rd=%b reg_wr=%b sext=%b expected be=%b wdata=%h mis=%b wr=%b rd=%b reg_wr=%b sext=1",
                 i, mem_be, mem_wdata, mem_misalign, mem_mem_wr, mem_mem_rd, mem_reg_wr, mem_mem_sext,
                 v[i].be, v[i].wdata, v[i].mis, v[i].exp_wr, v[i].exp_rd, !v[i].mis);
      else passed++;
    end
    set_idle;
    tick;
  endtask

  task automatic test_reset_while_held;
    mem_ready = 1'b1;
    set_ex(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h1111_2222, 5'd6, 32'h900);
    tick;
    mem_ready = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    total++;
    if ({mem_valid, mem_reg_wr, mem_mem_wr, mem_be, mem_wdata, mem_pc} !== '0)
      $display("FAIL reset_held: valid=%b reg_wr=%b wr=%b be=%b wdata=%h pc=%h expected all 0",
               mem_valid, mem_reg_wr, mem_mem_wr, mem_be, mem_wdata, mem_pc);
    else passed++;
`ifdef EX_MEM_STALL_CNT_EN
    total++;
    if (stall_cnt !== 32'd0) $display("FAIL reset_held_stall_cnt: got %0d expected 0", stall_cnt);
    else passed++;
`endif
    rst       = 1'b0;
    mem_ready = 1'b1;
    set_idle;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    mem_ready = 1'b1;
    set_idle;
    test_reset;
    test_store_byte;
    test_hold;
    test_misalign;
    test_flush;
    test_bubble;
    test_lanes;
    test_reset_while_held;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Parametrised EX/MEM pipeline register between the ALU stage and data-memory stage of the MIPS32 core.
- Adds over a plain register:
  - valid/ready handshake with back-pressure from a multi-cycle data memory
  - flush for branch/exception squash
  - registered store byte-lane alignment
  - misalignment detection
- Outputs feed the data-memory port and the MEM/WB register directly.

Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64; NB = DATA_W/8 byte lanes, OFS = log2(NB).
- REG_ADDR_W, 5, register-file address width.
- PC_W, 32, width of the carried PC (used for exception reporting).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  squash the entry being captured and the held entry
- ex_valid  in  1  EX presents a valid instruction
- ex_ready  out  1  stage can accept this cycle (combinational)
- ex_reg_wr  in  1  writes register file
- ex_mem_wr  in  1  store
- ex_mem_rd  in  1  load
- ex_mem_size  in  2  0 byte, 1 half, 2 word, 3 dword (dword only when DATA_W=64)
- ex_mem_sext  in  1  load sign-extend flag, passed through
- ex_alu_result  in  DATA_W  ALU result / effective address
- ex_store_data  in  DATA_W  rt value, right-aligned
- ex_waddr  in  REG_ADDR_W  destination register
- ex_pc  in  PC_W  instruction PC
- mem_valid  out  1  registered entry valid
- mem_ready  in  1  MEM stage consumes the entry this cycle
- mem_reg_wr, mem_mem_wr, mem_mem_rd, mem_mem_sext  out  1 each  registered controls
- mem_mem_size  out  2  registered size
- mem_alu_result  out  DATA_W  registered result/address
- mem_wdata  out  DATA_W  lane-aligned store data
- mem_be  out  NB  byte enables, one-hot per lane
- mem_waddr  out  REG_ADDR_W  registered destination
- mem_pc  out  PC_W  registered PC
- mem_misalign  out  1  address misaligned for access size

Behaviour:
- ex_ready = !mem_valid || mem_ready.
- Update priority per posedge clk: rst > flush > advance (ex_ready=1) > hold.
- rst: every output register cleared to 0, including mem_valid, all controls, mem_be, data, mem_waddr and mem_pc.
- flush: identical clear to rst, regardless of ex_ready or mem_ready; the EX input that cycle is dropped.
- Advance: mem_valid <= ex_valid; all fields captured. Latency is 1 cycle.
- Bubble: if ex_valid=0 on advance, mem_reg_wr, mem_mem_wr, mem_mem_rd, mem_be and mem_misalign are forced 0; data fields are still captured.
- Hold: all outputs are stable while mem_valid=1 and mem_ready=0.
- Alignment: a = ex_alu_result[OFS-1:0].
  - Byte: be = 1<<a; wdata = store_data[7:0] replicated across all lanes.
  - Half: be = 2'b11<<a; wdata = low halfword replicated.
  - Word: be = 4'hF<<a; wdata = low word replicated.
  - Dword: all lanes set; wdata = store_data.
  - Loads compute the same be; reads ignore wdata. Non-memory ops get be=0.
- Misaligned when, for a valid memory op (mem_wr or mem_rd):
  - half with a[0]=1
  - word with a[1:0]!=0
  - dword with a!=0
  - size 3 with DATA_W=32
- On misalignment: mem_misalign=1; mem_mem_wr, mem_mem_rd, mem_reg_wr and mem_be are forced 0; mem_valid stays 1 and mem_pc is kept so the exception unit can report it.
- ex_mem_wr and ex_mem_rd both 1 is illegal; treat it as a store.
- Reset asserted while an entry is held discards the entry with no partial state.

Optional Feature:
- Macro: EX_MEM_STALL_CNT_EN.
- Defined:
  - extra output port stall_cnt, 32 bits.
  - Increments every cycle with mem_valid=1 and mem_ready=0.
  - Saturates at 32'hFFFFFFFF.
  - Cleared only by rst; flush does not clear it.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- rst=1 for 2 cycles with random inputs -> all outputs 0, ex_ready=1.
- Valid store, size=0, alu_result=32'h1003, store_data=32'h000000AB, mem_ready=1 -> next cycle mem_be=4'b1000, mem_wdata=32'hABABABAB, mem_mem_wr=1, mem_valid=1.
- Valid entry loaded, then mem_ready=0 for 3 cycles while EX changes -> outputs unchanged, ex_ready=0; with the macro defined, stall_cnt goes 0→3.
- Word load at alu_result=32'h2002 -> mem_misalign=1, mem_mem_rd=0, mem_reg_wr=0, mem_be=0, mem_pc equals the input PC.
- Held entry plus flush=1 with mem_ready=0 -> next cycle mem_valid=0 and all controls 0; the following cycle a new ex_valid=1 entry is accepted.
- ex_valid=0 with ex_reg_wr=1 and mem_ready=1 -> mem_valid=0, mem_reg_wr=0 (bubble).
